// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, counter-width helper and the
// baud-period derivation used by both uart_rx and uart_tx.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width++;
            rem = rem >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

    function automatic int bit_period(input int clk_frequency, input int uart_frequency);
        return clk_frequency / uart_frequency;
    endfunction

    function automatic int half_period(input int bit_period_cycles);
        return bit_period_cycles / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side signal bundle: serial line in, byte and status pulses out.
interface uart_rx_if;

    logic       rx_bit;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;

    modport slave (
        input  rx_bit,
        output data,
        output valid,
        output framing_error,
        output busy
    );

    modport master (
        output rx_bit,
        input  data,
        input  valid,
        input  framing_error,
        input  busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; reset value is a parameter
// so an idle-high line comes out of reset already idle.
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic user_clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge user_clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, mid-bit sampling FSM, byte output with
// one-cycle valid / framing_error pulses and a BREAK state for held-low lines.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 125000000,
    parameter int UART_FREQUENCY = 38400
) (
    input  logic     user_clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);

    localparam int BIT_PERIOD  = bit_period(CLK_FREQUENCY, UART_FREQUENCY);
    localparam int HALF_PERIOD = half_period(BIT_PERIOD);
    localparam int CNT_W       = clog2(BIT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PERIOD - 1);

    rx_state_e        r_state;
    rx_state_e        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_framing_error;

    logic w_rx_s;
    logic w_cnt_last;
    logic w_half_done;
    logic w_busy;
    logic w_shift_en;
    logic w_frame_ok;
    logic w_frame_bad;

    uart_rx_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .user_clk (user_clk),
        .rst_n    (rst_n),
        .i_async  (bus.rx_bit),
        .o_sync   (w_rx_s)
    );

    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_half_done = (r_cnt == CNT_HALF);

    always_ff @(posedge user_clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (!w_rx_s)     w_next_state = START;
            START:   if (w_half_done) w_next_state = w_rx_s ? IDLE : DATA;
            DATA:    if (w_cnt_last && (r_bit_idx == 3'd7)) w_next_state = STOP;
            STOP:    if (w_cnt_last)  w_next_state = w_rx_s ? IDLE : BREAK;
            BREAK:   if (w_rx_s)      w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != IDLE);
        w_shift_en  = (r_state == DATA) && w_cnt_last;
        w_frame_ok  = (r_state == STOP) && w_cnt_last && w_rx_s;
        w_frame_bad = (r_state == STOP) && w_cnt_last && !w_rx_s;
    end

    // Counter restarts on every state entry so sample points are relative to that entry.
    always_ff @(posedge user_clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((w_next_state != r_state) || w_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge user_clk) begin
        if (!rst_n) begin
            r_bit_idx <= 3'd0;
        end else if (r_state != DATA) begin
            r_bit_idx <= 3'd0;
        end else if (w_shift_en) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // NOTE: the shift register has no reset; all 8 bits are rewritten before it is ever copied to data.
    always_ff @(posedge user_clk) begin
        if (w_shift_en) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
        end
    end

    always_ff @(posedge user_clk) begin
        if (!rst_n) begin
            r_data          <= 8'h00;
            r_valid         <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_valid         <= w_frame_ok;
            r_framing_error <= w_frame_bad;
            if (w_frame_ok) begin
                r_data <= r_shift;
            end
        end
    end

    assign bus.data          = r_data;
    assign bus.valid         = r_valid;
    assign bus.framing_error = r_framing_error;
    assign bus.busy          = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a fast instance (16 cycles/bit) for the frame
// cases and a default-parameter instance driven by a behavioural transmitter.
module tb_uart_rx;

    localparam int F_BIT = 16;
    localparam int D_BIT = 125000000 / 38400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_f;
    logic rst_n_d;

    uart_rx_if f_if ();
    uart_rx_if d_if ();

    uart_rx #(
        .CLK_FREQUENCY  (16),
        .UART_FREQUENCY (1)
    ) u_fast (
        .user_clk (clk),
        .rst_n    (rst_n_f),
        .bus      (f_if.slave)
    );

    uart_rx u_def (
        .user_clk (clk),
        .rst_n    (rst_n_d),
        .bus      (d_if.slave)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] q_f[$];
    logic [7:0] q_d[$];
    int         f_valid_cnt = 0;
    int         f_fe_cnt = 0;
    int         d_valid_cnt = 0;
    longint     d_valid_cyc = 0;
    longint     cyc = 0;
    bit         fe_allowed = 1'b0;
    logic       f_prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every valid and polices pulse rules.
    always @(negedge clk) begin
        if (rst_n_f) begin
            if (f_if.valid) begin
                f_valid_cnt++;
                check("valid_expected", 32'(q_f.size() != 0), 32'd1);
                if (q_f.size() != 0) check("rx_data", 32'(f_if.data), 32'(q_f.pop_front()));
                check("busy_before_valid", 32'(f_prev_busy), 32'd1);
                check("busy_fall_on_valid", 32'(f_if.busy), 32'd0);
                check("valid_fe_exclusive", 32'(f_if.framing_error), 32'd0);
            end
            if (f_if.framing_error) begin
                f_fe_cnt++;
                check("fe_expected", 32'(fe_allowed), 32'd1);
            end
        end
        f_prev_busy = f_if.busy;
        if (rst_n_d && d_if.valid) begin
            d_valid_cnt++;
            d_valid_cyc = cyc;
            check("def_valid_expected", 32'(q_d.size() != 0), 32'd1);
            if (q_d.size() != 0) check("def_rx_data", 32'(d_if.data), 32'(q_d.pop_front()));
        end
    end

    task automatic drive_f(input logic v, input int n);
        f_if.rx_bit = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic v, input int n);
        d_if.rx_bit = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_f(input logic [7:0] b, input logic stop_v);
        drive_f(1'b0, F_BIT);
        for (int i = 0; i < 8; i++) drive_f(b[i], F_BIT);
        drive_f(stop_v, F_BIT);
    endtask

    task automatic send_d(input logic [7:0] b);
        drive_d(1'b0, D_BIT);
        for (int i = 0; i < 8; i++) drive_d(b[i], D_BIT);
        drive_d(1'b1, D_BIT);
    endtask

    task automatic reset_checks(input string who, input logic [7:0] data, input logic valid,
                                input logic fe, input logic busy);
        check({who, "_reset_data"}, 32'(data), 32'd0);
        check({who, "_reset_valid"}, 32'(valid), 32'd0);
        check({who, "_reset_fe"}, 32'(fe), 32'd0);
        check({who, "_reset_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int     v0;
        int     fe0;
        int     busy_cycles;
        longint t0;

        f_if.rx_bit = 1'b1;
        d_if.rx_bit = 1'b1;
        rst_n_f = 1'b0;
        rst_n_d = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("fast", f_if.data, f_if.valid, f_if.framing_error, f_if.busy);
        reset_checks("def", d_if.data, d_if.valid, d_if.framing_error, d_if.busy);
        @(posedge clk);
        #1;
        rst_n_f = 1'b1;
        rst_n_d = 1'b1;
        drive_f(1'b1, 2 * F_BIT);

        // Good frame
        v0 = f_valid_cnt;
        fe0 = f_fe_cnt;
        q_f.push_back(8'hA5);
        send_f(8'hA5, 1'b1);
        drive_f(1'b1, F_BIT);
        check("a5_valid_count", 32'(f_valid_cnt - v0), 32'd1);
        check("a5_sb_empty", 32'(q_f.size()), 32'd0);

        // Back-to-back frames
        v0 = f_valid_cnt;
        q_f.push_back(8'h00);
        q_f.push_back(8'hFF);
        send_f(8'h00, 1'b1);
        send_f(8'hFF, 1'b1);
        drive_f(1'b1, F_BIT);
        check("b2b_valid_count", 32'(f_valid_cnt - v0), 32'd2);
        check("b2b_sb_empty", 32'(q_f.size()), 32'd0);
        check("b2b_no_fe", 32'(f_fe_cnt - fe0), 32'd0);

        // Short glitch shorter than half a bit
        v0 = f_valid_cnt;
        busy_cycles = 0;
        drive_f(1'b0, 4);
        f_if.rx_bit = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (f_if.busy) busy_cycles++;
        end
        @(posedge clk);
        #1;
        check("glitch_busy_seen", 32'(busy_cycles > 0), 32'd1);
        check("glitch_busy_max", 32'(busy_cycles <= F_BIT / 2 + 2), 32'd1);
        check("glitch_no_valid", 32'(f_valid_cnt - v0), 32'd0);
        check("glitch_no_fe", 32'(f_fe_cnt - fe0), 32'd0);

        // Framing error followed by a held-low break
        fe_allowed = 1'b1;
        v0 = f_valid_cnt;
        send_f(8'h3C, 1'b0);
        drive_f(1'b0, 100);
        check("fe_pulse_count", 32'(f_fe_cnt - fe0), 32'd1);
        check("fe_data_held", 32'(f_if.data), 32'hFF);
        check("fe_no_valid", 32'(f_valid_cnt - v0), 32'd0);
        @(negedge clk);
        check("break_busy", 32'(f_if.busy), 32'd1);
        @(posedge clk);
        #1;
        drive_f(1'b1, 2 * F_BIT);
        fe_allowed = 1'b0;
        check("break_released", 32'(f_if.busy), 32'd0);
        q_f.push_back(8'h5A);
        send_f(8'h5A, 1'b1);
        drive_f(1'b1, F_BIT);
        check("after_break_valid", 32'(f_valid_cnt - v0), 32'd1);
        check("after_break_sb_empty", 32'(q_f.size()), 32'd0);

        // Reset during data bit 4 of an aborted frame (bits 4..7 high)
        v0 = f_valid_cnt;
        drive_f(1'b0, F_BIT);
        for (int i = 0; i < 4; i++) drive_f(1'b0, F_BIT);
        drive_f(1'b1, F_BIT / 2);
        check("busy_mid_frame", 32'(f_if.busy), 32'd1);
        rst_n_f = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_checks("midframe", f_if.data, f_if.valid, f_if.framing_error, f_if.busy);
        @(posedge clk);
        #1;
        rst_n_f = 1'b1;
        drive_f(1'b1, 5 * F_BIT);
        check("midframe_no_valid", 32'(f_valid_cnt - v0), 32'd0);
        q_f.push_back(8'hC3);
        send_f(8'hC3, 1'b1);
        drive_f(1'b1, F_BIT);
        check("c3_valid_count", 32'(f_valid_cnt - v0), 32'd1);
        check("c3_sb_empty", 32'(q_f.size()), 32'd0);

        // Default parameters, behavioural transmitter into rx_bit
        q_d.push_back(8'hA5);
        t0 = cyc;
        send_d(8'hA5);
        for (int i = 0; i < D_BIT && d_valid_cnt == 0; i++) @(posedge clk);
        check("def_valid_count", 32'(d_valid_cnt), 32'd1);
        check("def_latency_window",
              32'((d_valid_cyc - t0 >= 9 * D_BIT) && (d_valid_cyc - t0 <= 10 * D_BIT)), 32'd1);
        check("def_sb_empty", 32'(q_d.size()), 32'd0);
        check("def_data_out", 32'(d_if.data), 32'hA5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of uart_tx. Deserialises 8N1 frames from the external serial line into bytes.
- Intended use: the host sends IAGC commands and configuration bytes to the board. uart_rx sits between the board RX pin and the command/config logic.
- Same clock and baud parameters as uart_tx, so both ends of the link share one configuration.

Parameters:
- CLK_FREQUENCY, 125000000, user_clk frequency in Hz.
- UART_FREQUENCY, 38400, baud rate in bit/s.
- Derived localparams:
  - BIT_PERIOD = CLK_FREQUENCY/UART_FREQUENCY, integer division; 3255 at defaults.
  - HALF_PERIOD = BIT_PERIOD/2; 1627 at defaults.

Ports:
- user_clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- rx_bit  input  1  asynchronous serial line; idles high.
- data  output  8  last received byte; LSB = first data bit on the wire.
- valid  output  1  one-cycle pulse; data is valid in that cycle.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE; data = 8'h00; valid = 0; framing_error = 0; busy = 0.
  - Counters cleared; synchroniser flops set to 1.
  - Reset takes effect even mid-frame. The partial byte is discarded and no pulse is emitted.
- Input synchronisation: rx_bit passes through 2 flops, giving rx_s. All decisions use rx_s. This adds 2 cycles of latency, which is not compensated.
- Baud counter: counts 0..BIT_PERIOD-1, then reloads. It is cleared on every state entry.
- FSM states:
  - IDLE: busy = 0. On rx_s == 0 go to START with counter = 0.
  - START: wait HALF_PERIOD cycles, then sample.
    - rx_s == 0: go to DATA with bit index 0 and counter = 0.
    - rx_s == 1: glitch. Return to IDLE with no pulse.
  - DATA: each time the counter reaches BIT_PERIOD-1, shift rx_s into the shift register MSB (right shift, LSB-first).
    - After the 8th sample, go to STOP.
  - STOP: after BIT_PERIOD cycles, sample rx_s.
    - 1: data <= shift register; valid = 1 for exactly one cycle; go to IDLE.
    - 0: framing_error = 1 for one cycle; data is unchanged; go to BREAK.
  - BREAK: stay until rx_s == 1, then go to IDLE. This prevents a held-low line from being decoded as a stream of 0x00 frames.
- Sample point: every data and stop sample lands at mid-bit (start edge + k*BIT_PERIOD + HALF_PERIOD, plus synchroniser delay).
- valid and framing_error are never high in the same cycle.
- data holds its value until the next good frame.
- No overrun handling: the consumer must take data in the valid cycle. Back-to-back frames are supported.
  - After a good stop sample the FSM is in IDLE half a bit before the stop bit ends.
  - It must accept a start edge immediately after the stop bit.
- Tolerance: correct reception for baud mismatch up to ±2%.

Decomposition:
- Shared package/header uart_defs.vh, holding:
  - State encodings: IDLE, START, DATA, STOP, BREAK.
  - A clog2 function for counter widths.
  - The BIT_PERIOD/HALF_PERIOD derivation, so that uart_tx can adopt the same derivation.
- One sub-module, uart_rx_sync: 2-flop synchroniser with a reset value of 1. It is also reusable for other async inputs.
- The FSM, baud counter and shift register stay in uart_rx.

Test Plan:
- Use bench parameters CLK_FREQUENCY=16, UART_FREQUENCY=1 (BIT_PERIOD=16) for the fast cases. One case uses the defaults.
- Good frame: send 8'hA5 (wire order 1,0,1,0,0,1,0,1 after start) → single valid pulse with data=8'hA5; framing_error never high; busy falls in the same cycle valid rises.
- Back-to-back frames: send 8'h00 then 8'hFF with no idle gap → two valid pulses with data 8'h00, then 8'hFF; no framing_error.
- Glitch: drive rx_bit low for 4 cycles (< HALF_PERIOD) → FSM returns to IDLE; no valid or framing_error; busy high for at most HALF_PERIOD + 2 cycles.
- Framing error and break: send 8'h3C with stop bit 0, then hold line low 100 cycles → one framing_error pulse only; data keeps its previous value; busy stays high until the line returns high; a following 8'h5A frame is received correctly.
- Reset mid-frame: assert rst_n=0 for 1 cycle during data bit 4 → all outputs 0 the next cycle; no valid for that frame; the next full frame 8'hC3 is received.
- Default parameters, loopback: connect uart_tx (data=8'b10100101) tx_bit to rx_bit, both at 125 MHz / 38400 baud → valid with data=8'hA5 about 10*3255 cycles after start_tx.
